divider_32bit: RTL and testbench
================================

Name: divider_32bit

Overview:
- Multi-cycle signed 32-bit integer divider for the CPU execute stage.
- It is the inverse counterpart of the multiplier path: it takes dividend and divisor and returns the quotient, one quotient bit per clock.
- The pipeline stalls on busy and captures data_result when data_resultRDY pulses.

Parameters:
- WIDTH, 32, operand and result width; only 32 is verified.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- data_operandA  in  32  dividend, two's complement.
- data_operandB  in  32  divisor, two's complement.
- ctrl_DIV  in  1  start pulse; sampled only in IDLE or DONE.
- data_result  out  32  quotient, truncated toward zero.
- data_exception  out  1  divide-by-zero or overflow flag, valid with data_resultRDY.
- data_resultRDY  out  1  one-cycle pulse; data_result and data_exception are valid.
- busy  out  1  high while the state is RUN or ZERO.

Behaviour:
- Reset: state IDLE. data_result=0, data_exception=0, data_resultRDY=0, busy=0. Count, remainder and quotient registers are cleared.
- States and transitions:
  - IDLE: if ctrl_DIV=1 at an edge, latch both operands and go to RUN or ZERO (see start rules).
  - RUN: one restoring step per edge.
  - ZERO: one-cycle state for divide-by-zero.
  - DONE: holds data_resultRDY high for exactly one cycle, then goes to IDLE. If ctrl_DIV=1 in DONE, start a new divide as from IDLE.
- Start rules, applied at the accepting edge:
  - divisor==0: go to ZERO. The next edge enters DONE with data_result=0 and data_exception=1.
  - dividend==0x80000000 and divisor==0xFFFFFFFF: go to RUN as normal. On entering DONE, data_result=0x80000000 and data_exception=1.
  - Otherwise: store |A| and |B| as unsigned. Store sign = A[31]^B[31]. Set remainder=0 and count=0.
- RUN step, once per edge:
  - Shift {remainder, dividend} left by 1.
  - Compute trial = remainder − |B| as a 33-bit signed value.
  - If trial ≥ 0: remainder=trial and quotient bit=1. Otherwise keep remainder and set the bit to 0.
  - Increment count. After the 32nd step (count==31 at the edge), the next edge enters DONE.
- DONE entry:
  - data_result = sign ? −quotient : quotient.
  - data_exception=0 unless one of the exception cases above applies.
  - data_result and data_exception then hold their values until the next DONE entry.
- Latency:
  - Normal divide: ctrl_DIV sampled at edge E0, 32 RUN steps at E1..E32, DONE entered at E33. data_resultRDY is high in the cycle after E33.
  - Divide-by-zero: DONE entered at E2.
- Boundary cases:
  - ctrl_DIV while busy=1 is ignored; the operation in flight is unaffected.
  - Operand changes after the accepting edge have no effect, because operands are latched.
  - Reset during RUN or ZERO aborts the divide: back to IDLE, all outputs 0, and no data_resultRDY pulse.
  - Reset and ctrl_DIV in the same cycle: reset wins.
  - |dividend| < |divisor| gives quotient 0 and data_exception=0.
  - The remainder is computed internally but is not an output.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32.
  - DIV_CNT_W=5.
  - The state encoding: IDLE=2'd0, RUN=2'd1, ZERO=2'd2, DONE=2'd3.
  - INT_MIN=32'h80000000.
- Sub-module div_step: combinational. Inputs are the 32-bit remainder, the incoming dividend MSB and the 32-bit divisor. Outputs are the next remainder and the quotient bit.
- The top level holds the FSM, the counter, the operand, quotient and remainder registers, the sign fix-up and the output registers.

Test Plan:
- Basic: reset, then A=100, B=7, pulse ctrl_DIV. Expect data_resultRDY exactly 33 cycles after the accepting edge, data_result=14, exception=0, busy=1 during RUN.
- Signs:
  - A=−100, B=7 → data_result=0xFFFFFFF2 (−14).
  - A=100, B=−7 → −14.
  - A=−100, B=−7 → 14.
  - A=3, B=5 → 0.
- Divide-by-zero: A=42, B=0. Expect data_resultRDY 2 cycles after the accepting edge, data_result=0, exception=1.
- Overflow and large values:
  - A=0x80000000, B=0xFFFFFFFF → data_result=0x80000000, exception=1.
  - A=0x7FFFFFFF, B=1 → 0x7FFFFFFF, exception=0.
- Ignored start: pulse ctrl_DIV with new operands 10 cycles into a divide. The first result (100/7=14) is unaffected and the second request produces no extra data_resultRDY.
- Reset mid-operation: assert reset at cycle 15 of RUN. Expect all outputs 0 and busy=0 the next cycle, and no data_resultRDY. A following 9/3 divide gives 3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU execute-stage definitions used by the divider.
// Contents: word/counter widths, divider FSM state encoding, INT_MIN constant
// and a two's-complement magnitude helper.
package cpu_pkg;

  localparam int WORD_W    = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [WORD_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ZERO = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Magnitude of a two's-complement word, returned as unsigned.
  // INT_MIN maps to 0x80000000, which is the correct unsigned magnitude.
  function automatic logic [WORD_W-1:0] abs_w(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? ({WORD_W{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (combinational).
// Ports:
//   rem_i  - current partial remainder (always < dvs_i)
//   msb_i  - next dividend bit shifted into the remainder
//   dvs_i  - unsigned divisor magnitude
//   rem_o  - next partial remainder
//   q_o    - quotient bit produced by this step
module div_step
  import cpu_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] rem_i,
  input  logic         msb_i,
  input  logic [W-1:0] dvs_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // rem_i < dvs_i <= 2^(W-1), so the shifted value and the trial difference
  // both fit a W+1 bit signed range; trial[W] is the sign.
  assign shifted = {rem_i, msb_i};
  assign trial   = shifted - {1'b0, dvs_i};
  assign q_o     = ~trial[W];
  assign rem_o   = q_o ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/divider_32bit.sv
// Multi-cycle signed 32-bit divider, one quotient bit per clock.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   data_operandA/B       - dividend / divisor (two's complement), latched on start
//   ctrl_DIV              - start request, honoured only in IDLE or DONE
//   data_result           - quotient truncated toward zero (held until next result)
//   data_exception        - divide-by-zero or INT_MIN/-1 overflow
//   data_resultRDY        - one-cycle pulse marking a new result
//   busy                  - high while a divide is in flight (RUN or ZERO)
module divider_32bit
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(WIDTH - 1);

  div_state_e state_q, state_d;

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;   // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 sign_q, sign_d;
  logic                 ovf_q, ovf_d;
  // fin_q: the next edge leaves RUN/ZERO for DONE. It gives RUN one extra
  // cycle after the last step and stretches ZERO to two cycles.
  logic                 fin_q, fin_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 exc_q, exc_d;
  logic                 rdy_q, rdy_d;

  logic                 start;
  logic                 b_zero;
  logic [WIDTH-1:0]     step_rem;
  logic                 step_bit;

  assign start  = ctrl_DIV && (state_q == IDLE || state_q == DONE);
  assign b_zero = (data_operandB == '0);

  div_step #(.W(WIDTH)) u_step (
    .rem_i (rem_q),
    .msb_i (quo_q[WIDTH-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ctrl_DIV) state_d = b_zero ? ZERO : RUN;
      RUN:     if (fin_q)    state_d = DONE;
      ZERO:    if (fin_q)    state_d = DONE;
      DONE:    state_d = ctrl_DIV ? (b_zero ? ZERO : RUN) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture and restoring steps
  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    sign_d = sign_q;
    ovf_d  = ovf_q;
    fin_d  = fin_q;
    if (start) begin
      dvs_d  = abs_w(data_operandB);
      quo_d  = abs_w(data_operandA);
      rem_d  = '0;
      cnt_d  = '0;
      sign_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      ovf_d  = (data_operandA == INT_MIN) && (data_operandB == '1);
      fin_d  = 1'b0;
    end else if (state_q == RUN) begin
      if (fin_q) begin
        fin_d = 1'b0;
      end else begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_bit};
        cnt_d = cnt_q + 1'b1;
        fin_d = (cnt_q == LAST_STEP);
      end
    end else if (state_q == ZERO) begin
      fin_d = ~fin_q;
    end
  end

  // Output logic: result registers load on DONE entry only
  always_comb begin
    res_d = res_q;
    exc_d = exc_q;
    rdy_d = 1'b0;
    if (fin_q && state_q == ZERO) begin
      res_d = '0;
      exc_d = 1'b1;
      rdy_d = 1'b1;
    end else if (fin_q && state_q == RUN) begin
      // INT_MIN / -1 yields magnitude 0x80000000 with positive sign,
      // which is already the wrapped result; only the flag differs.
      res_d = sign_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
      exc_d = ovf_q;
      rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      sign_q <= 1'b0;
      ovf_q  <= 1'b0;
      fin_q  <= 1'b0;
      res_q  <= '0;
      exc_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      sign_q <= sign_d;
      ovf_q  <= ovf_d;
      fin_q  <= fin_d;
      res_q  <= res_d;
      exc_q  <= exc_d;
      rdy_q  <= rdy_d;
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = (state_q == RUN) || (state_q == ZERO);

endmodule

// File: tb/tb_divider_32bit.sv
// Self-checking bench for divider_32bit: directed cases plus random operands
// compared against a plain-arithmetic reference model.
module tb_divider_32bit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  int n_checks = 0;
  int n_fail   = 0;

  divider_32bit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed division truncating toward zero, with the two
  // exception cases handled explicitly.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; e = 1'b1;
    end else begin
      q = sa / sb; e = 1'b0;
    end
  endfunction

  // Issue one divide, scramble the operand inputs after acceptance, wait for
  // the result pulse (bounded), then check latency, value, flag and pulse width.
  // inj > 0: fire a second ctrl_DIV that many cycles after the accepting edge.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int inj);
    logic [31:0] eq;
    logic        ee;
    int          lat, k;
    model(a, b, eq, ee);
    lat = (b == 32'd0) ? 2 : 33;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    k = 0;
    while (!data_resultRDY && k < 45) begin
      @(posedge clock); #1;
      k++;
      ctrl_DIV = 1'b0;
      if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (inj > 0 && k == inj) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd50;
        data_operandB = 32'd5;
      end
    end
    ctrl_DIV = 1'b0;
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_result"}, data_result, eq);
    chk({tag, "_exc"}, 32'(data_exception), 32'(ee));
    @(posedge clock); #1;
    chk({tag, "_rdy_pulse"}, 32'(data_resultRDY), 32'd0);
  endtask

  task automatic count_rdy(input string tag, input int cycles);
    int extra = 0;
    repeat (cycles) begin
      @(posedge clock); #1;
      if (data_resultRDY) extra++;
    end
    chk(tag, 32'(extra), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", 32'(data_exception), 32'd0);
    chk("rst_rdy", 32'(data_resultRDY), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_div("basic", 32'd100, 32'd7, 0);
    run_div("neg_a", -32'sd100, 32'd7, 0);
    run_div("neg_b", 32'd100, -32'sd7, 0);
    run_div("neg_ab", -32'sd100, -32'sd7, 0);
    run_div("small", 32'd3, 32'd5, 0);
    run_div("div0", 32'd42, 32'd0, 0);
    run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div("max", 32'h7FFF_FFFF, 32'd1, 0);
    run_div("min_by_1", 32'h8000_0000, 32'd1, 0);
    run_div("min_by_2", 32'h8000_0000, 32'd2, 0);

    // Start request while busy must be ignored
    run_div("ignored", 32'd100, 32'd7, 10);
    count_rdy("ignored_no_extra", 40);

    // Reset 15 cycles into RUN aborts with no result pulse
    @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd3;
    ctrl_DIV      = 1'b1;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (15) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", 32'(data_exception), 32'd0);
    chk("abort_rdy", 32'(data_resultRDY), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    count_rdy("abort_no_rdy", 40);
    run_div("after_abort", 32'd9, 32'd3, 0);

    // Reset and start in the same cycle: reset wins
    @(negedge clock);
    reset = 1'b1;
    ctrl_DIV = 1'b1;
    data_operandA = 32'd5;
    data_operandB = 32'd1;
    @(posedge clock); #1;
    chk("rst_vs_start_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ctrl_DIV = 1'b0;
    @(posedge clock); #1;
    chk("rst_vs_start_idle", 32'(busy), 32'd0);

    // Random operands: mix full-range, small-divisor and zero-divisor cases
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom;
        1:       rb = $urandom_range(1, 1000);
        2:       rb = -($urandom_range(1, 1000));
        default: rb = (i % 8 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      endcase
      run_div("rand", ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
